// File: rtl/mbscore_mem_responder.sv
// mbscore_mem_responder
//
// Memory-side responder for the core's shared memory bus. It holds a word-addressed RAM
// window at BASE_ADDR and answers level-sensitive read/write requests on a tristate data bus.
// Reads are stretched by WAIT_CYCLES wait states, and the core is stalled through `pause`.
// Writes complete in one cycle. The bus is driven only while returning read data, so other
// peripherals outside the window can share it.
//
// Read timeline: the request cycle, then WAIT_CYCLES+1 further clock edges, then data.
// `pause` is high in the request cycle and in every wait cycle. With WAIT_CYCLES=0 the
// responder goes from the request straight to DRIVE, so `pause` is high for one cycle only.
//
// Optional feature (compile-time macro MBSCORE_MEM_STATS_EN):
//   Adds the input stats_clr and the saturating 16-bit counters rd_cnt and wr_cnt.
//   rd_cnt counts completed reads (entries into DRIVE); wr_cnt counts performed writes.
//   stats_clr wins over an increment in the same cycle.
//
// Ports:
//   clk        in     system clock
//   rst_n      in     synchronous active-low reset
//   addr_bus   in     byte address from the core; bits [1:0] are ignored
//   data_bus   inout  shared data bus; driven only while returning read data
//   ram_re     in     read request (level)
//   ram_we     in     write request (level)
//   pause      out    stall to the core while a selected read is pending
//   sel        out    combinational: addr_bus lies inside the window
//   proto_err  out    one-cycle pulse, one cycle after a protocol violation
//   stats_clr  in     (MBSCORE_MEM_STATS_EN) synchronous clear of both counters
//   rd_cnt     out    (MBSCORE_MEM_STATS_EN) completed-read counter
//   wr_cnt     out    (MBSCORE_MEM_STATS_EN) performed-write counter

module mbscore_mem_responder #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           DEPTH_LOG2  = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr_bus,
    inout  wire  [DATA_WIDTH-1:0] data_bus,
    input  logic                  ram_re,
    input  logic                  ram_we,
    output logic                  pause,
    output logic                  sel,
    output logic                  proto_err
`ifdef MBSCORE_MEM_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt
`endif
);

    localparam int unsigned TAG_LSB = DEPTH_LOG2 + 2;
    localparam int unsigned WORDS   = 2 ** DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    // Elaboration-time parameter checks.
    if (WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("mbscore_mem_responder: WAIT_CYCLES must be in 0..15");
    end
    if (BASE_ADDR[TAG_LSB-1:0] != '0) begin : g_bad_base_addr
        $error("mbscore_mem_responder: BASE_ADDR must be aligned to the window size");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            state_q,   state_d;
    logic [DEPTH_LOG2-1:0] lat_idx_q, lat_idx_d;
    logic [3:0]            cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] rdbuf_q,   rdbuf_d;
    logic                  perr_q,    perr_d;

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [DEPTH_LOG2-1:0] idx;
    logic                  same_idx;
    logic                  rd_req;
    logic                  wr_req;
    logic                  unused_addr_lsb;

    assign sel             = (addr_bus[ADDR_WIDTH-1:TAG_LSB] == BASE_ADDR[ADDR_WIDTH-1:TAG_LSB]);
    assign idx             = addr_bus[TAG_LSB-1:2];
    assign same_idx        = (idx == lat_idx_q);
    assign rd_req          = sel & ram_re & ~ram_we;
    assign wr_req          = sel & ram_we;
    assign unused_addr_lsb = ^addr_bus[1:0];

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    logic                  start_rd;
    logic                  rd_load;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  wr_en;
    logic                  oe;

    always_comb begin
        state_d   = state_q;
        lat_idx_d = lat_idx_q;
        cnt_d     = cnt_q;
        rdbuf_d   = rdbuf_q;
        perr_d    = 1'b0;
        start_rd  = 1'b0;
        rd_load   = 1'b0;
        rd_addr   = lat_idx_q;
        wr_en     = 1'b0;
        oe        = 1'b0;
        pause     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    // A simultaneous read request is dropped and flagged.
                    wr_en  = 1'b1;
                    perr_d = ram_re;
                end else if (rd_req) begin
                    start_rd = 1'b1;
                end
            end

            ST_WAIT: begin
                pause = 1'b1;
                if (!ram_re) begin
                    // The core gave up on the read: abandon it silently.
                    state_d = ST_IDLE;
                end else begin
                    // Writes and address moves are ignored here; the read continues
                    // to the latched word.
                    perr_d = ram_we | ~sel | ~same_idx;
                    // The counter reaches zero at this edge: the last wait state ends.
                    if (cnt_q <= 4'd1) begin
                        rd_load = 1'b1;
                        state_d = ST_DRIVE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end

            ST_DRIVE: begin
                if (wr_req) begin
                    // The bus is released this cycle so the core's write data is not
                    // contended.
                    wr_en   = 1'b1;
                    perr_d  = ram_re;
                    state_d = ST_IDLE;
                end else if (!(sel && ram_re)) begin
                    state_d = ST_IDLE;
                end else if (!same_idx) begin
                    start_rd = 1'b1;
                end else begin
                    oe = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_rd) begin
            pause     = 1'b1;
            lat_idx_d = idx;
            cnt_d     = WAIT_LOAD;
            if (NO_WAIT) begin
                // No wait states: fetch at the request edge itself.
                rd_load = 1'b1;
                rd_addr = idx;
                state_d = ST_DRIVE;
            end else begin
                state_d = ST_WAIT;
            end
        end

        if (rd_load) begin
            rdbuf_d = mem_q[rd_addr];
        end

        // While reset is held, no request is accepted and the bus stays released.
        if (!rst_n) begin
            pause = 1'b0;
            oe    = 1'b0;
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lat_idx_q <= '0;
            cnt_q     <= '0;
            rdbuf_q   <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_idx_q <= lat_idx_d;
            cnt_q     <= cnt_d;
            rdbuf_q   <= rdbuf_d;
            perr_q    <= perr_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= data_bus;
        end
    end

    assign data_bus  = oe ? rdbuf_q : 'z;
    assign proto_err = perr_q;

`ifdef MBSCORE_MEM_STATS_EN
    // ------------------------------------------------------------------
    // Saturating access counters
    // ------------------------------------------------------------------
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (stats_clr) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end else begin
            if (rd_load && rst_n && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_d = rd_cnt_q + 16'd1;
            end
            if (wr_en && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule
